// File: rtl/alu_cmd_driver.sv
// Drives one ALU command at a time, checks the returned result against a golden model, and keeps verdict counters.
// Latency: issue 1 cycle after accept, verdict after the result or TIMEOUT wait cycles; cmd_ready stays low until the verdict.
module alu_cmd_driver #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [1:0]       alu_op_in,
  output logic [WIDTH-1:0] alu_a_in,
  output logic [WIDTH-1:0] alu_b_in,
  output logic             alu_in_valid,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_out_valid,
  output logic             rsp_valid,
  output logic             rsp_ok,
  output logic             rsp_timeout,
  output logic [WIDTH-1:0] rsp_expected,
  output logic [WIDTH-1:0] rsp_got,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_exp;
  logic [WC_W-1:0]  r_wait_cnt;
  logic             r_timed_out;
  logic             r_match;
  logic             w_last;

  function automatic logic [WIDTH-1:0] f_golden(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  assign w_last = (r_wait_cnt == WC_LAST);

  always_comb begin
    w_next       = r_state;
    cmd_ready    = 1'b0;
    alu_in_valid = 1'b0;
    rsp_valid    = 1'b0;
    rsp_ok       = 1'b0;
    rsp_timeout  = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        alu_in_valid = 1'b1;
        w_next       = S_WAIT;
      end
      S_WAIT: begin
        if (alu_out_valid || w_last) w_next = S_REPORT;
      end
      S_REPORT: begin
        rsp_valid   = 1'b1;
        rsp_ok      = r_match;
        rsp_timeout = r_timed_out;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_exp        <= '0;
      r_wait_cnt   <= '0;
      r_timed_out  <= 1'b0;
      r_match      <= 1'b0;
      alu_op_in    <= '0;
      alu_a_in     <= '0;
      alu_b_in     <= '0;
      rsp_expected <= '0;
      rsp_got      <= '0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      timeout_cnt  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            alu_op_in <= cmd_op;
            alu_a_in  <= cmd_a;
            alu_b_in  <= cmd_b;
            r_exp     <= f_golden(cmd_op, cmd_a, cmd_b);
          end
        end
        S_ISSUE: r_wait_cnt <= '0;
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + WC_W'(1);
          // A result on the last wait cycle takes priority over the timeout.
          if (alu_out_valid) begin
            rsp_expected <= r_exp;
            rsp_got      <= alu_out;
            r_timed_out  <= 1'b0;
            r_match      <= (alu_out == r_exp);
          end else if (w_last) begin
            rsp_expected <= r_exp;
            rsp_got      <= '0;
            r_timed_out  <= 1'b1;
            r_match      <= 1'b0;
          end
        end
        S_REPORT: begin
          if (r_timed_out) begin
            if (timeout_cnt != CNT_MAX) timeout_cnt <= timeout_cnt + CNT_W'(1);
          end else if (r_match) begin
            if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
          end else begin
            if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
